wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//  Write-back side of the integer register file: merges results from the ALU (single-cycle)
//  and the long-latency units (LSU loads, MDU mul/div) onto the single regfile write port
//  (wen/wraddr/wrdata). Long-latency results queue in a small FIFO. A pending-write
//  scoreboard lets the issue stage detect RAW hazards on registers with writes in flight.
// PARAMETERS
//  FIFO_DEPTH  4   entries in the long-latency result FIFO (power of 2, >=2)
//  DATA_W      32  result data width
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous active-high reset
//  hold         in   1       pipeline stall; freezes retire, issue and ALU capture
//  alu_valid    in   1       ALU result present (no backpressure)
//  alu_rd       in   5       ALU destination register
//  alu_data     in   DATA_W  ALU result
//  lsu_valid    in   1       load result offered
//  lsu_ready    out  1       load result accepted this cycle
//  lsu_rd       in   5       load destination
//  lsu_data     in   DATA_W  load data
//  mdu_valid    in   1       MDU result offered
//  mdu_ready    out  1       MDU result accepted this cycle
//  mdu_rd       in   5       MDU destination
//  mdu_data     in   DATA_W  MDU result
//  issue_valid  in   1       long-latency op issued this cycle
//  issue_rd     in   5       its destination register
//  chk_addr1    in   5       hazard query address 1
//  chk_busy1    out  1       pending[chk_addr1] (combinational)
//  chk_addr2    in   5       hazard query address 2
//  chk_busy2    out  1       pending[chk_addr2] (combinational)
//  wen          out  1       regfile write enable (registered)
//  wraddr       out  32      regfile write address, zero-extended rd (registered)
//  wrdata       out  DATA_W  regfile write data (registered)
//  sb_err       out  1       sticky: issue to an rd already pending
// BEHAVIOUR
//  Reset: wen=0, wraddr=0, wrdata=0, sb_err=0, FIFO empty, pending=0, RR pointer -> LSU.
//   Reset mid-operation discards queued results and all pending bits.
//  Enqueue: one entry/cycle; round-robin between LSU and MDU when both valid (grant toggles
//   after each accept); lone requester granted. x_ready = granted & count<FIFO_DEPTH;
//   count-only check (no credit from same-cycle pop). Enqueue allowed during hold.
//   Accepted results with rd=0 are consumed but not stored.
//  Retire (per edge, hold=0): if alu_valid & alu_rd!=0 -> wen=1, ALU result;
//   else if FIFO non-empty -> pop head, wen=1; else wen=0. ALU always wins.
//   alu_valid with rd=0 writes nothing; FIFO may drain that cycle.
//   Latency: ALU result -> wen 1 cycle; FIFO entry retires >=1 cycle after its enqueue edge.
//  hold=1: wen registered 0, no pop, alu input ignored, issue ignored, pending unchanged.
//  Scoreboard: 32-bit pending bitmap. issue_valid & issue_rd!=0 & ~hold sets bit;
//   FIFO pop clears bit of popped rd at the same edge wen rises. Same-edge set+clear of one
//   bit -> set wins. Issue to a bit already set (not being cleared) -> sb_err=1 until rst.
//   pending[0] hardwired 0.
//  Empty FIFO + pop never occurs; full FIFO -> both readies 0.
// TESTING
//  rst; alu_valid rd=5 data=0xDEADBEEF -> next cycle wen=1 wraddr=5 wrdata=0xDEADBEEF.
//  issue rd=7 -> chk_busy1(7)=1; mdu rd=7 0x1234 enqueued edge E1, ALU idle -> wen rd7 0x1234
//   after E2, chk_busy1=0 after E2.
//  lsu rd=3 queued while alu_valid 3 cycles (rd 1,2,4) -> writes 1,2,4 then 3.
//  lsu rd=8 & mdu rd=9 valid together from reset -> LSU accepted first, MDU next; retire 8,9.
//  ALU busy, 4 results queued -> ready=0 on both; hold=1 2 cycles -> wen=0, FIFO intact.
//  alu rd=0 / issue rd=0 -> no wen, no busy; issue rd=6 twice -> sb_err=1 sticky.

Source files
------------

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: the ALU result path takes priority over a FIFO of
// long-latency results (LSU/MDU), plus a pending-write scoreboard for RAW hazard checks.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [4:0]        lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [4:0]        mdu_rd,
  input  logic [DATA_W-1:0] mdu_data,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  input  logic [4:0]        chk_addr1,
  output logic              chk_busy1,
  input  logic [4:0]        chk_addr2,
  output logic              chk_busy2,
  output logic              wen,
  output logic [31:0]       wraddr,
  output logic [DATA_W-1:0] wrdata,
  output logic              sb_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]        fifo_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              rr_mdu;
  logic [31:0]       pending, pending_next;

  logic              not_full, grant_lsu, grant_mdu, accept, push, alu_take, pop;
  logic [4:0]        push_rd, pop_rd;
  logic [DATA_W-1:0] push_data;
  logic              issue_set, err_set;

  // Enqueue arbitration: round-robin only matters when both units offer together
  assign not_full  = count < CNT_W'(FIFO_DEPTH);
  assign grant_lsu = lsu_valid & (~mdu_valid | ~rr_mdu);
  assign grant_mdu = mdu_valid & (~lsu_valid | rr_mdu);
  assign lsu_ready = grant_lsu & not_full;
  assign mdu_ready = grant_mdu & not_full;
  assign accept    = lsu_ready | mdu_ready;
  assign push_rd   = lsu_ready ? lsu_rd : mdu_rd;
  assign push_data = lsu_ready ? lsu_data : mdu_data;
  assign push      = accept & (push_rd != 5'd0);

  assign alu_take  = ~hold & alu_valid & (alu_rd != 5'd0);
  assign pop       = ~hold & ~alu_take & (count != '0);
  assign pop_rd    = fifo_rd[rd_ptr];

  assign chk_busy1 = pending[chk_addr1];
  assign chk_busy2 = pending[chk_addr2];

  // A same-edge issue re-sets a bit being cleared by pop, so set is applied last
  always_comb begin
    pending_next = pending;
    issue_set    = issue_valid & ~hold & (issue_rd != 5'd0);
    err_set      = 1'b0;
    if (pop)
      pending_next[pop_rd] = 1'b0;
    if (issue_set) begin
      err_set                = pending[issue_rd] & ~(pop & (pop_rd == issue_rd));
      pending_next[issue_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rr_mdu  <= 1'b0;
      pending <= '0;
      sb_err  <= 1'b0;
      wen     <= 1'b0;
      wraddr  <= '0;
      wrdata  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (accept)
        rr_mdu <= lsu_ready;
      pending <= pending_next;
      if (err_set)
        sb_err <= 1'b1;
      wen <= alu_take | pop;
      if (alu_take) begin
        wraddr <= {27'd0, alu_rd};
        wrdata <= alu_data;
      end else if (pop) begin
        wraddr <= {27'd0, pop_rd};
        wrdata <= fifo_data[rd_ptr];
      end
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by count alone
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= push_rd;
      fifo_data[wr_ptr] <= push_data;
    end
  end

endmodule
